// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder with valid/ready handshake.
// Stage 1 captures per-bit generate/propagate and per-group G/P terms.
// Stage 2 resolves group and bit carries in flattened lookahead form and
// registers sum, carry-out and signed overflow.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = WIDTH / GROUP;

  generate
    if (GROUP != 4 || WIDTH < 4 || (WIDTH % GROUP) != 0) begin : g_bad_param
      $error("cla_pipe_adder: GROUP must be 4 and WIDTH a multiple of 4 (>= 4)");
    end
  endgenerate

  // Carry out of bit 'hi' given carry into bit 'lo', written as a flat
  // sum-of-products so no carry ripples through intermediate positions.
  function automatic logic la_carry(input logic [WIDTH-1:0] gv,
                                    input logic [WIDTH-1:0] pv,
                                    input logic             c0,
                                    input int               lo,
                                    input int               hi);
    logic c;
    logic t;
    c = c0;
    for (int j = lo; j <= hi; j++) c = c & pv[j];
    for (int j = lo; j <= hi; j++) begin
      t = gv[j];
      for (int m = j + 1; m <= hi; m++) t = t & pv[m];
      c = c | t;
    end
    return c;
  endfunction

  logic             s2_adv;
  logic             s1_adv;
  logic             ld_p1;

  logic [WIDTH-1:0] g_c, p_c;
  logic [NG-1:0]    gg_c, pg_c;

  logic             vld_p1;
  logic [WIDTH-1:0] g_p1, p_p1;
  logic [NG-1:0]    gg_p1, pg_p1;
  logic             cin_p1;

  logic [WIDTH-1:0] ggx, pgx;
  logic [NG:0]      cg_c;
  logic [WIDTH:0]   c_c;
  logic [WIDTH-1:0] sum_c;

  logic             vld_p2;

  // Handshake: stage 1 may advance whenever stage 2 can; rst blocks input.
  assign s2_adv    = !vld_p2 || out_ready;
  assign s1_adv    = s2_adv;
  assign in_ready  = !rst && (!vld_p1 || s1_adv);
  assign ld_p1     = in_valid && in_ready;
  assign out_valid = vld_p2;

  // ---- stage 0 -> 1: bit and group generate/propagate ----
  assign g_c = a & b;
  assign p_c = a ^ b;

  // Group G/P terms for each 4-bit group.
  always_comb begin
    gg_c = '0;
    pg_c = '0;
    for (int k = 0; k < NG; k++) begin
      gg_c[k] = g_c[4*k+3]
              | (p_c[4*k+3] & g_c[4*k+2])
              | (p_c[4*k+3] & p_c[4*k+2] & g_c[4*k+1])
              | (p_c[4*k+3] & p_c[4*k+2] & p_c[4*k+1] & g_c[4*k]);
      pg_c[k] = &p_c[4*k +: 4];
    end
  end

  // Stage 1 valid flag.
  always_ff @(posedge clk) begin
    if (rst)         vld_p1 <= 1'b0;
    else if (ld_p1)  vld_p1 <= 1'b1;
    else if (s1_adv) vld_p1 <= 1'b0;
  end

  // Stage 1 data capture; data is unqualified and needs no reset.
  always_ff @(posedge clk) begin
    if (ld_p1) begin
      g_p1   <= g_c;
      p_p1   <= p_c;
      gg_p1  <= gg_c;
      pg_p1  <= pg_c;
      cin_p1 <= cin;
    end
  end

  // ---- stage 1 -> 2: lookahead carry resolution ----
  assign ggx = {{(WIDTH-NG){1'b0}}, gg_p1};
  assign pgx = {{(WIDTH-NG){1'b0}}, pg_p1};

  // Group carries from group G/P, then bit carries inside each group
  // seeded by that group's carry-in.
  always_comb begin
    cg_c    = '0;
    c_c     = '0;
    cg_c[0] = cin_p1;
    for (int k = 0; k < NG; k++) cg_c[k+1] = la_carry(ggx, pgx, cin_p1, 0, k);
    for (int k = 0; k < NG; k++) begin
      c_c[4*k] = cg_c[k];
      for (int i = 1; i < 4; i++)
        c_c[4*k+i] = la_carry(g_p1, p_p1, cg_c[k], 4*k, 4*k+i-1);
    end
    c_c[WIDTH] = cg_c[NG];
  end

  assign sum_c = p_p1 ^ c_c[WIDTH-1:0];

  // Stage 2 result register; held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (vld_p1 && s2_adv) begin
      vld_p2 <= 1'b1;
      sum    <= sum_c;
      cout   <= c_c[WIDTH];
      ovf    <= c_c[WIDTH-1] ^ c_c[WIDTH];
    end else if (s2_adv) begin
      vld_p2 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=16): directed vector table,
// handshake corner sequences and random traffic against a queue-based model.
module tb_cla_pipe_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } res_t;

  vec_t vecs[9];
  res_t q[$];
  res_t held;
  logic stall_prev;
  int   checks;
  int   errors;

  // Reference: plain integer arithmetic, overflow from the true signed sum.
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic ci);
    res_t        r;
    int unsigned t;
    int          sx, sy, st;
    t    = x + y + ci;
    sx   = $signed(x);
    sy   = $signed(y);
    st   = sx + sy + int'(ci);
    r.s  = t[15:0];
    r.co = t[16];
    r.ov = (st > 32767) || (st < -32768);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive on negedge, observe after settling, update model.
  task automatic cycle(input logic r, input logic v, input logic [15:0] xa,
                       input logic [15:0] xb, input logic xc, input logic ordy);
    res_t e;
    @(negedge clk);
    rst = r; in_valid = v; a = xa; b = xb; cin = xc; out_ready = ordy;
    #1;
    if (stall_prev) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_sum", sum, held.s);
      chk("stall_cout", cout, held.co);
      chk("stall_ovf", ovf, held.ov);
    end
    stall_prev = out_valid && !out_ready && !r;
    held.s = sum; held.co = cout; held.ov = ovf;
    if (r) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("out_has_ref", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("sb_sum", sum, e.s);
          chk("sb_cout", cout, e.co);
          chk("sb_ovf", ovf, e.ov);
        end
      end
      if (in_valid && in_ready) q.push_back(model(xa, xb, xc));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      cycle(0, 0, 16'($urandom), 16'($urandom), 0, 1);
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int nout;
    checks = 0; errors = 0; stall_prev = 1'b0;
    rst = 1'b1; in_valid = 1'b1; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[6] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[7] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};
    vecs[8] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    // Reset held with in_valid asserted.
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 16'hAAAA, 16'h5555, 1, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
    end
    cycle(0, 0, 16'h0, 16'h0, 0, 1);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_sum", sum, 0);
    chk("post_rst_cout", cout, 0);
    chk("post_rst_ovf", ovf, 0);

    // Directed vectors, one at a time, checking the two-cycle latency.
    for (int i = 0; i < 9; i++) begin
      cycle(0, 1, vecs[i].a, vecs[i].b, vecs[i].ci, 1);
      cycle(0, 0, 16'h0, 16'h0, 0, 1);
      chk("lat_not_yet", out_valid, 0);
      cycle(0, 0, 16'h0, 16'h0, 0, 1);
      chk("lat_valid", out_valid, 1);
      chk("vec_sum", sum, vecs[i].s);
      chk("vec_cout", cout, vecs[i].co);
      chk("vec_ovf", ovf, vecs[i].ov);
    end

    // Back-to-back: 8 operand sets, results on 8 consecutive cycles.
    nout = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(0, i < 8, 16'($urandom), 16'($urandom), 1'($urandom), 1);
      if (i < 8) chk("b2b_in_ready", in_ready, 1);
      if (out_valid) begin
        chk("b2b_slot", i, 2 + nout);
        nout++;
      end
    end
    chk("b2b_count", nout, 8);
    drain();

    // Stall with stage 1 empty: exactly one further accept, then in_ready=0.
    cycle(0, 1, 16'h1111, 16'h2222, 0, 1);
    cycle(0, 0, 16'h0, 16'h0, 0, 1);
    cycle(0, 1, 16'h3333, 16'h4444, 1, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_extra_accept", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 16'h5555, 16'h6666, 0, 0);
      chk("bp_blocked", in_ready, 0);
    end
    chk("bp_inflight", q.size(), 2);
    drain();

    // Stall after full-rate streaming: both stages full, input blocked.
    for (int i = 0; i < 4; i++) cycle(0, 1, 16'($urandom), 16'($urandom), 1'($urandom), 1);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 16'($urandom), 16'($urandom), 1'($urandom), 0);
      chk("bp2_blocked", in_ready, 0);
    end
    chk("bp2_inflight", q.size(), 2);
    drain();

    // Random traffic on both handshakes.
    for (int i = 0; i < 400; i++)
      cycle(0, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0));
    drain();

    // Reset with both stages holding results.
    cycle(0, 1, 16'h0F0F, 16'h0101, 0, 0);
    cycle(0, 1, 16'hF0F0, 16'h1010, 1, 0);
    cycle(0, 1, 16'h1234, 16'h1234, 0, 0);
    chk("mid_pre_inflight", q.size(), 2);
    cycle(1, 1, 16'h0, 16'h0, 0, 1);
    cycle(0, 0, 16'h0, 16'h0, 0, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 16'h0, 16'h0, 0, 1);
      chk("mid_no_stale", out_valid, 0);
    end
    cycle(0, 1, 16'h7FFF, 16'h7FFF, 1, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
